// File: rtl/tcdm_bist_master_if.sv
// TCDM bank-port bundle: request/grant channel from the initiator plus the read-response channel.
interface tcdm_bist_master_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] add;
  logic                  wen;
  logic [31:0]           data;
  logic [3:0]            be;
  logic [31:0]           r_data;
  logic                  r_valid;

  modport master (output req, add, wen, data, be, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, data, be, output gnt, r_data, r_valid);
endinterface

// File: rtl/tcdm_bist_master.sv
// Memory BIST initiator: writes seed^index over a word range, reads it back through a
// 2-deep expectation FIFO and reports mismatch count and first failing byte address.
module tcdm_bist_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  input  logic [31:0]           seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ERR_WIDTH-1:0]  err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  tcdm_bist_master_if.master    tcdm
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [31:0]           seed_q, seed_d;
  logic [CNT_WIDTH-1:0]  k_q, k_d;
  logic                  error_q, error_d;
  logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;

  logic [31:0]           fifo_data_mem [2];
  logic [ADDR_WIDTH-1:0] fifo_addr_mem [2];

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           cur_data;
  logic                  last_word, fifo_full, xfer, push, pop, mismatch;

  assign cur_addr  = base_q + (ADDR_WIDTH'(k_q) << 2);
  assign cur_data  = seed_q ^ 32'(k_q);
  assign last_word = (k_q == n_q - CNT_WIDTH'(1));
  assign fifo_full = (fifo_cnt_q == 2'd2);
  assign xfer      = tcdm.req & tcdm.gnt;
  assign push      = xfer & (state_q == S_READ);
  // Responses only count while a read phase owns the FIFO; strays are dropped.
  assign pop       = tcdm.r_valid & (fifo_cnt_q != 2'd0) &
                     ((state_q == S_READ) | (state_q == S_DRAIN));
  assign mismatch  = pop & (tcdm.r_data != fifo_data_mem[rd_ptr_q]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = (num_words_i != '0) ? S_WRITE : S_DONE;
      S_WRITE: if (xfer && last_word) state_d = S_READ;
      S_READ:  if (xfer && last_word) state_d = S_DRAIN;
      S_DRAIN: if (fifo_cnt_d == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    base_d     = base_q;
    n_d        = n_q;
    seed_d     = seed_q;
    k_d        = k_q;
    error_d    = error_q;
    err_cnt_d  = err_cnt_q;
    first_d    = first_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    fifo_cnt_d = fifo_cnt_q;
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (state_q == S_IDLE && start_i) begin
      base_d    = base_addr_i;
      n_d       = num_words_i;
      seed_d    = seed_i;
      k_d       = '0;
      error_d   = 1'b0;
      err_cnt_d = '0;
      first_d   = '0;
    end
    if (xfer) k_d = (state_q == S_WRITE && last_word) ? '0 : k_q + CNT_WIDTH'(1);

    if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
      if (!error_q) begin
        error_d = 1'b1;
        first_d = fifo_addr_mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q     <= '0;
      n_q        <= '0;
      seed_q     <= '0;
      k_q        <= '0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
      first_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      base_q     <= base_d;
      n_q        <= n_d;
      seed_q     <= seed_d;
      k_q        <= k_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
      first_q    <= first_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage has no reset; the occupancy counter alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_mem[wr_ptr_q] <= cur_data;
      fifo_addr_mem[wr_ptr_q] <= cur_addr;
    end
  end

  always_comb begin
    tcdm.req  = 1'b0;
    tcdm.wen  = 1'b1;
    tcdm.add  = '0;
    tcdm.data = '0;
    tcdm.be   = 4'hF;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      S_WRITE: begin
        tcdm.req  = 1'b1;
        tcdm.wen  = 1'b0;
        tcdm.add  = cur_addr;
        tcdm.data = cur_data;
        busy_o    = 1'b1;
      end
      S_READ: begin
        tcdm.req = !fifo_full;
        tcdm.add = cur_addr;
        busy_o   = 1'b1;
      end
      S_DRAIN: busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign error_o          = error_q;
  assign err_count_o      = err_cnt_q;
  assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_tcdm_bist_master.sv
// Scoreboard bench: a behavioural bank slave answers the BIST engine, expected bus
// transfers and run results are queued up front and a negedge monitor checks them.
module tb_tcdm_bist_master;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_words;
  logic [31:0] seed;
  logic        busy, done, error;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;

  tcdm_bist_master_if #(.ADDR_WIDTH(32)) bus ();

  tcdm_bist_master #(.ADDR_WIDTH(32), .CNT_WIDTH(16), .ERR_WIDTH(16)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .base_addr_i      (base_addr),
    .num_words_i      (num_words),
    .seed_i           (seed),
    .busy_o           (busy),
    .done_o           (done),
    .error_o          (error),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr),
    .tcdm             (bus)
  );

  typedef struct {
    logic        wen;
    logic [31:0] add;
    logic [31:0] data;
  } tx_t;

  typedef struct {
    logic        err;
    logic [15:0] cnt;
    logic [31:0] first;
    bit          chk_first;
  } res_t;

  tx_t  exp_tx[$];
  res_t exp_res[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bank slave: optional random grant stalls, read data one cycle after grant,
  // selectable single-address or all-address bit-0 corruption of read data.
  logic [31:0] mem [logic [31:0]];
  bit          stall_en = 0, flip_en = 0, flip_all = 0;
  logic [31:0] flip_addr = '0;
  bit          rd_pend = 0;
  logic [31:0] rd_pend_data = '0;

  initial begin
    bus.gnt     = 1'b0;
    bus.r_valid = 1'b0;
    bus.r_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.r_valid = rd_pend;
      bus.r_data  = rd_pend ? rd_pend_data : 32'h0;
      rd_pend     = 0;
      bus.gnt     = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (!rst && bus.req && bus.gnt) begin
        if (bus.wen) begin
          rd_pend      = 1;
          rd_pend_data = mem.exists(bus.add) ? mem[bus.add] : 32'hDEAD_BEEF;
          if (flip_all || (flip_en && bus.add == flip_addr)) rd_pend_data[0] = ~rd_pend_data[0];
        end else begin
          mem[bus.add] = bus.data;
        end
      end
    end
  end

  // Monitor: bus transfers against exp_tx, done pulses against exp_res, hold stability.
  int          first_gnt_cyc, last_gnt_cyc, done_cyc, start_cyc;
  int          n_wr, n_rd;
  bit          any_req, busy_seen, done_seen, first_gnt_seen;
  bit          hold_v = 0;
  logic [31:0] hold_add, hold_data;
  logic        hold_wen;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        check("hold_req", bus.req, 1'b1);
        check("hold_add", bus.add, hold_add);
        check("hold_wen", bus.wen, hold_wen);
        check("hold_data", bus.data, hold_data);
      end
      hold_v = 0;
      if (busy) busy_seen = 1;
      if (bus.req) begin
        any_req = 1;
        check("busy_during_req", busy, 1'b1);
        if (bus.gnt) begin
          check("grant_expected", 64'(exp_tx.size() != 0), 1);
          if (exp_tx.size() != 0) begin
            tx_t t;
            t = exp_tx.pop_front();
            check("tx_wen", bus.wen, t.wen);
            check("tx_add", bus.add, t.add);
            if (!t.wen) check("tx_data", bus.data, t.data);
          end
          if (bus.wen) n_rd++;
          else n_wr++;
          if (!first_gnt_seen) first_gnt_cyc = cyc;
          first_gnt_seen = 1;
          last_gnt_cyc = cyc;
        end else begin
          hold_v    = 1;
          hold_add  = bus.add;
          hold_wen  = bus.wen;
          hold_data = bus.data;
        end
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        check("busy_at_done", busy, 1'b0);
        check("result_expected", 64'(exp_res.size() != 0), 1);
        if (exp_res.size() != 0) begin
          res_t r;
          r = exp_res.pop_front();
          check("error_o", error, r.err);
          check("err_count_o", err_count, r.cnt);
          if (r.chk_first) check("first_err_addr_o", first_err_addr, r.first);
        end
      end
    end
  end

  task automatic push_txs(input logic [31:0] b, input int n, input logic [31:0] s);
    for (int k = 0; k < n; k++) exp_tx.push_back('{wen: 1'b0, add: b + 32'(4 * k), data: s ^ 32'(k)});
    for (int k = 0; k < n; k++) exp_tx.push_back('{wen: 1'b1, add: b + 32'(4 * k), data: 32'h0});
  endtask

  task automatic launch(input logic [31:0] b, input int n, input logic [31:0] s);
    n_wr = 0; n_rd = 0; any_req = 0; busy_seen = 0; done_seen = 0; first_gnt_seen = 0;
    push_txs(b, n, s);
    @(negedge clk);
    base_addr = b;
    num_words = 16'(n);
    seed      = s;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = done_seen;
    end
    check("done_within_budget", ok, 1'b1);
    if (!ok) begin
      exp_tx.delete();
      exp_res.delete();
    end
  endtask

  task automatic run(input logic [31:0] b, input int n, input logic [31:0] s, input res_t r);
    exp_res.push_back(r);
    launch(b, n, s);
    wait_done(2000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; seed = '0;
    repeat (3) @(negedge clk);
    check("rst_req", bus.req, 1'b0);
    check("rst_wen", bus.wen, 1'b1);
    check("rst_be", bus.be, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_error", error, 1'b0);
    check("idle_err_count", err_count, 16'h0);
    check("idle_first_addr", first_err_addr, 32'h0);
    check("idle_add", bus.add, 32'h0);
    check("idle_data", bus.data, 32'h0);

    // Clean run, full throughput, 1-cycle latency.
    run(32'h1000_0000, 4, 32'hA5A5_0000, '{err: 1'b0, cnt: 16'd0, first: 32'h0, chk_first: 1'b0});
    check("t1_writes", n_wr, 4);
    check("t1_reads", n_rd, 4);
    check("t1_grant_span", last_gnt_cyc - first_gnt_cyc, 7);
    check("t1_done_latency", done_cyc - last_gnt_cyc, 2);
    check("t1_mem_word3", mem[32'h1000_000C], 32'hA5A5_0003);

    // Word 2 read back with bit 0 flipped.
    flip_en = 1; flip_addr = 32'h1000_0008;
    run(32'h1000_0000, 4, 32'hA5A5_0000, '{err: 1'b1, cnt: 16'd1, first: 32'h1000_0008, chk_first: 1'b1});
    flip_en = 0;

    // Zero-length start right after a failing run clears error state.
    run(32'h1000_0000, 0, 32'h0, '{err: 1'b0, cnt: 16'd0, first: 32'h0, chk_first: 1'b0});
    check("t3_no_req", any_req, 1'b0);
    check("t3_no_busy", busy_seen, 1'b0);
    check("t3_done_soon", 64'((done_cyc - start_cyc) <= 2), 1);

    // Random stalls, N=16, with a start pulse while busy that must be ignored.
    stall_en = 1;
    exp_res.push_back('{err: 1'b0, cnt: 16'd0, first: 32'h0, chk_first: 1'b0});
    launch(32'h2000_0000, 16, 32'h1234_5678);
    repeat (5) @(negedge clk);
    base_addr = 32'h0000_BAD0; num_words = 16'd1; seed = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    stall_en = 0;
    check("t4_writes", n_wr, 16);
    check("t4_reads", n_rd, 16);

    // Several mismatches: count accumulates, first address is the lowest word.
    flip_all = 1;
    run(32'h6000_0000, 3, 32'h0F0F_0000, '{err: 1'b1, cnt: 16'd3, first: 32'h6000_0000, chk_first: 1'b1});
    flip_all = 0;

    // Address wrap at the top of the space: FFFF_FFF8, FFFF_FFFC, 0, 4.
    run(32'hFFFF_FFF8, 4, 32'hC0DE_0000, '{err: 1'b0, cnt: 16'd0, first: 32'h0, chk_first: 1'b0});
    check("t6_mem_wrap0", mem[32'h0000_0000], 32'hC0DE_0002);
    check("t6_mem_wrap4", mem[32'h0000_0004], 32'hC0DE_0003);

    // Reset with one read outstanding; the late (corrupted) response must be ignored.
    flip_en = 1; flip_addr = 32'h4000_0000;
    launch(32'h4000_0000, 4, 32'h5555_0000);
    for (int i = 0; i < 100 && n_rd == 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("t7_read_granted", 64'(n_rd != 0), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t7_req_async_drop", bus.req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_tx.delete();
    @(negedge clk);
    #1;
    flip_en = 0;
    check("t7_busy", busy, 1'b0);
    check("t7_done", done, 1'b0);
    check("t7_error", error, 1'b0);
    check("t7_err_count", err_count, 16'h0);
    check("t7_req", bus.req, 1'b0);
    check("t7_wen", bus.wen, 1'b1);
    check("t7_add", bus.add, 32'h0);
    run(32'h5000_0000, 4, 32'h3333_0000, '{err: 1'b0, cnt: 16'd0, first: 32'h0, chk_first: 1'b0});
    check("t7_rerun_writes", n_wr, 4);
    check("t7_rerun_reads", n_rd, 4);

    repeat (3) @(negedge clk);
    check("tx_queue_empty", exp_tx.size(), 0);
    check("res_queue_empty", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tcdm_bist_master.md
Name: tcdm_bist_master

Overview:
- Initiator-side engine for one TCDM bank port (hci_mem_intf request/grant plus response signals).
- On start it fills a word range with a deterministic pattern, then reads the range back and compares every word.
- Reports pass/fail, mismatch count and the first failing address.
- Sits beside the bank wrappers; used for post-init memory test and for bench stimulus of bank slaves.

Parameters:
ADDR_WIDTH, 32, width of tcdm_add_o and base_addr_i (byte address)
CNT_WIDTH, 16, width of num_words_i and the internal word index
ERR_WIDTH, 16, width of err_count_o (saturating)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  start pulse; sampled only in IDLE
base_addr_i  in  ADDR_WIDTH  first byte address, word aligned; sampled at start
num_words_i  in  CNT_WIDTH  words to test; sampled at start
seed_i  in  32  pattern seed; sampled at start
busy_o  out  1  high from the cycle after accepted start until done
done_o  out  1  one-cycle pulse at completion
error_o  out  1  sticky: at least one mismatch in the last run
err_count_o  out  ERR_WIDTH  mismatches in the last run, saturating
first_err_addr_o  out  ADDR_WIDTH  byte address of the first mismatch
tcdm_req_o  out  1  request
tcdm_gnt_i  in  1  grant
tcdm_add_o  out  ADDR_WIDTH  byte address
tcdm_wen_o  out  1  1 = read, 0 = write
tcdm_data_o  out  32  write data
tcdm_be_o  out  4  byte enables, constant 4'hF
tcdm_r_data_i  in  32  read data
tcdm_r_valid_i  in  1  read data valid

Behaviour:
- Reset: state IDLE. All outputs 0, except tcdm_wen_o = 1 and tcdm_be_o = 4'hF. Counters and error state cleared.
- Reset mid-run: tcdm_req_o drops asynchronously. In-flight responses after reset release are ignored (state is IDLE).
- Pattern: word k (0..N-1) has address base + 4*k, modulo 2^ADDR_WIDTH (wraps, no error). Data is seed ^ zero-extended k.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: on start_i with num_words_i != 0, latch inputs, clear error state, go to WRITE.
- IDLE, zero-length start: start_i with num_words_i == 0 goes straight to DONE, issues no requests, error_o = 0.
- start_i outside IDLE is ignored.
- Request handshake: transfer occurs on tcdm_req_o & tcdm_gnt_i. While req is high and gnt is low, add/wen/data hold stable.
- Back-to-back: after a grant the next request may be presented the next cycle (one per cycle at full throughput).
- WRITE: req = 1, wen = 0, data = pattern(k). k advances on each grant. After the grant of k = N-1, reset k to 0 and go to READ.
- READ: req = 1, wen = 1. On each grant, push the expected word and its address into a 2-entry pending FIFO. After the grant of k = N-1, go to DRAIN.
- Response handling in READ and DRAIN: each r_valid pops the pending FIFO and compares r_data to the expected word.
  - On mismatch: err_count increments, saturating at all-ones.
  - On the first mismatch only: capture first_err_addr_o and set error_o.
- Response latency: r_valid nominally arrives one cycle after grant. The block tolerates any latency ≥1 with at most 2 outstanding reads.
- Backpressure: READ deasserts req while the FIFO is full.
- r_valid with an empty FIFO, or outside READ/DRAIN, is ignored.
- DRAIN: req = 0. When the FIFO is empty, go to DONE.
- DONE: done_o = 1 for one cycle, busy_o = 0, then IDLE.
- Result outputs hold until the next accepted start.
- busy_o is 1 in WRITE, READ and DRAIN only.
- Grant and response in the same cycle: both are processed; FIFO push and pop are simultaneous, occupancy unchanged.

Test Plan:
- Always-grant slave, 1-cycle latency; base 0x1000_0000, N=4, seed 0xA5A5_0000.
  → writes 0xA5A5_0000..0xA5A5_0003 to 0x1000_0000..0x1000_000C.
  → 8 grants in 8 consecutive cycles; done_o 2 cycles after the last grant; error_o = 0, err_count_o = 0.
- Same setup, but the slave returns word 2 with bit 0 flipped.
  → error_o = 1, err_count_o = 1, first_err_addr_o = 0x1000_0008.
- Random gnt stalls (~50%), N=16.
  → add/wen/data stable while req & !gnt; exactly 16 writes then 16 reads; no mismatch.
- num_words_i = 0.
  → no tcdm_req_o ever; done_o pulses 2 cycles after start; busy_o stays 0.
- base 0xFFFF_FFF8, N=4.
  → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- rst_i asserted in READ with 1 read outstanding.
  → tcdm_req_o falls in the same cycle; outputs return to reset values; the late r_valid is ignored; a new start runs cleanly.
